// File: rtl/ga_best_unit_if.sv
// Control, bank-load and result signals of the GA best-of-population unit.
// The master side drives seed/start/ext_*, the slave side (the unit) drives
// busy/done/best_*.
interface ga_best_unit_if #(
  parameter int CHROM_W = 8,
  parameter int FIT_W   = 27
);
  logic [31:0]             seed;
  logic                    start;
  logic                    ext_we;
  logic [3:0]              ext_addr;
  logic signed [FIT_W-1:0] ext_fit;
  logic                    busy;
  logic                    done;
  logic [7:0]              best_index;
  logic [CHROM_W-1:0]      best_chrom;
  logic signed [FIT_W-1:0] best_fit;

  modport master (
    output seed, start, ext_we, ext_addr, ext_fit,
    input  busy, done, best_index, best_chrom, best_fit
  );

  modport slave (
    input  seed, start, ext_we, ext_addr, ext_fit,
    output busy, done, best_index, best_chrom, best_fit
  );
endinterface

// File: rtl/ga_best_unit.sv
// GA evaluation block: xorshift32 chromosome source (two per clock), a
// one-stage fitness pipeline, a 16-entry chromosome/fitness bank and a
// combinational arg-max selector whose result is registered on best_*.
module ga_best_unit #(
  parameter int N_POP   = 16,
  parameter int CHROM_W = 8,
  parameter int FIT_W   = 27
) (
  input  logic         clk,
  input  logic         reset,
  ga_best_unit_if.slave bus
);

  localparam int AW = $clog2(N_POP);
  localparam int KW = $clog2(N_POP / 2);
  localparam logic [KW-1:0]         K_LAST   = KW'(N_POP / 2 - 1);
  localparam logic signed [FIT_W-1:0] SEL_INIT = FIT_W'(-(1 <<< (FIT_W - 1)) + 1);
  localparam logic signed [FIT_W-1:0] K15      = FIT_W'(15);
  localparam logic signed [FIT_W-1:0] K500     = FIT_W'(500);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, EVAL} state_t;

  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // f(x) = x^3 - 15x^2 + 500 with x the chromosome read as signed.
  function automatic logic signed [FIT_W-1:0] fitness(input logic [CHROM_W-1:0] c);
    logic signed [FIT_W-1:0] x;
    logic signed [FIT_W-1:0] x2;
    x  = FIT_W'($signed(c));
    x2 = x * x;
    return x2 * x - K15 * x2 + K500;
  endfunction

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [31:0]             rng_q;
  logic [CHROM_W-1:0]      chrom_q [N_POP];
  logic signed [FIT_W-1:0] fit_q   [N_POP];
  logic [AW-1:0]           best_idx_q;
  logic [CHROM_W-1:0]      best_chrom_q;
  logic signed [FIT_W-1:0] best_fit_q;

  logic                    cap_en;
  logic                    sel_load;
  logic                    ext_wr;
  logic [CHROM_W-1:0]      rnd1, rnd2;
  logic [AW-1:0]           sel_idx;
  logic signed [FIT_W-1:0] sel_max;

  logic signed [FIT_W-1:0] fa_p0, fb_p0;
  logic                    vld_p0;
  logic [KW-1:0]           k_p0;

  assign rnd1 = rng_q[CHROM_W-1:0];
  assign rnd2 = rng_q[2*CHROM_W-1:CHROM_W];

  // Arg-max over the bank; strict compare keeps the lowest index on ties.
  always_comb begin
    sel_max = SEL_INIT;
    sel_idx = '0;
    for (int i = 0; i < N_POP; i++) begin
      if (fit_q[i] > sel_max) begin
        sel_max = fit_q[i];
        sel_idx = AW'(i);
      end
    end
  end

  // Next-state and control decode for the fill/drain/evaluate sequence.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cap_en   = 1'b0;
    sel_load = 1'b0;
    ext_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_load = 1'b1;
        if (bus.start) begin
          state_d = FILL;
          k_d     = '0;
          busy_d  = 1'b1;
        end else if (bus.ext_we) begin
          ext_wr = 1'b1;
        end
      end
      FILL: begin
        cap_en = 1'b1;
        if (k_q == K_LAST) state_d = DRAIN;
        else               k_d     = k_q + 1'b1;
      end
      DRAIN: state_d = EVAL;
      EVAL: begin
        sel_load = 1'b1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, handshake flags and the free-running RNG.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rng_q   <= (bus.seed == 32'h0) ? 32'h0000_0001 : bus.seed;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rng_q   <= xorshift32(rng_q);
    end
  end

  // Stage p0: fitness of the pair captured this cycle, valid tags it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      k_p0   <= '0;
    end else begin
      vld_p0 <= cap_en;
      k_p0   <= k_q;
    end
  end

  // Fitness datapath register; contents are only used when vld_p0 is set.
  always_ff @(posedge clk) begin
    fa_p0 <= fitness(rnd1);
    fb_p0 <= fitness(rnd2);
  end

  // Bank writes: chromosomes at capture, fitness one cycle later, or ext load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_POP; i++) begin
        chrom_q[i] <= '0;
        fit_q[i]   <= '0;
      end
    end else begin
      if (cap_en) begin
        chrom_q[{k_q, 1'b0}] <= rnd1;
        chrom_q[{k_q, 1'b1}] <= rnd2;
      end
      if (vld_p0) begin
        fit_q[{k_p0, 1'b0}] <= fa_p0;
        fit_q[{k_p0, 1'b1}] <= fb_p0;
      end
      if (ext_wr) fit_q[bus.ext_addr[AW-1:0]] <= bus.ext_fit;
    end
  end

  // Result registers: refreshed every IDLE cycle and on the EVAL step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_idx_q   <= '0;
      best_chrom_q <= '0;
      best_fit_q   <= '0;
    end else if (sel_load) begin
      best_idx_q   <= sel_idx;
      best_chrom_q <= chrom_q[sel_idx];
      best_fit_q   <= fit_q[sel_idx];
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.best_index = {{(8 - AW){1'b0}}, best_idx_q};
  assign bus.best_chrom = best_chrom_q;
  assign bus.best_fit   = best_fit_q;

endmodule

// File: tb/tb_ga_best_unit.sv
// Self-checking bench for ga_best_unit: reference xorshift32 and fitness
// model, scoreboard queue of expected best_* results.
module tb_ga_best_unit;

  typedef struct {
    logic [7:0]         idx;
    logic [7:0]         chr;
    logic signed [26:0] fit;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ga_best_unit_if bus ();

  ga_best_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int nerr = 0;
  int nchk = 0;

  logic [31:0]        m;
  logic signed [26:0] mfit [16];
  logic [7:0]         mchr [16];
  exp_t               sbq [$];

  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic signed [26:0] fitf(input logic [7:0] c);
    int x;
    x = int'($signed(c));
    return 27'(x * x * x - 15 * x * x + 500);
  endfunction

  function automatic exp_t ref_best();
    exp_t r;
    int bi;
    int bv;
    bi = 0;
    bv = -(1 << 26) + 1;
    for (int i = 0; i < 16; i++) begin
      if (int'(mfit[i]) > bv) begin
        bv = int'(mfit[i]);
        bi = i;
      end
    end
    r.idx = 8'(bi);
    r.chr = mchr[bi];
    r.fit = mfit[bi];
    return r;
  endfunction

  // Reference RNG tracks the DUT state cycle by cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) m <= (bus.seed == 32'h0) ? 32'h1 : bus.seed;
    else        m <= xs(m);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_index"}, 32'(bus.best_index), 32'(e.idx));
      chk({tag, "_chrom"}, 32'(bus.best_chrom), 32'(e.chr));
      chk({tag, "_fit"},   32'(bus.best_fit),   32'(e.fit));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      mfit[i] = '0;
      mchr[i] = '0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy),       32'd0);
    chk({tag, "_done"},  32'(bus.done),       32'd0);
    chk({tag, "_index"}, 32'(bus.best_index), 32'd0);
    chk({tag, "_chrom"}, 32'(bus.best_chrom), 32'd0);
    chk({tag, "_fit"},   32'(bus.best_fit),   32'd0);
  endtask

  task automatic do_reset(input logic [31:0] s);
    bus.seed = s;
    reset    = 1'b0;
    #1;
    chk_zero("reset");
    tick();
    tick();
    reset = 1'b1;
    clear_model();
  endtask

  // Start pulse at edge 0 (optionally a second one at edge 4); done must
  // appear exactly after edge 10 with busy high after edges 0..9.
  task automatic run_start(input string tag, input bit dbl);
    logic [31:0] s;
    s = m;
    bus.start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = xs(s);
      mchr[2*k]   = s[7:0];
      mchr[2*k+1] = s[15:8];
      mfit[2*k]   = fitf(s[7:0]);
      mfit[2*k+1] = fitf(s[15:8]);
    end
    sbq.push_back(ref_best());
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
    chk({tag, "_done0"}, 32'(bus.done), 32'd0);
    for (int j = 1; j <= 11; j++) begin
      bus.start = dbl && (j == 4);
      tick();
      if (j <= 9) begin
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
      end else if (j == 10) begin
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        pop_cmp(tag);
      end else begin
        chk({tag, "_done_once"}, 32'(bus.done), 32'd0);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic load(input int a, input logic signed [26:0] v);
    bus.ext_we   = 1'b1;
    bus.ext_addr = 4'(a);
    bus.ext_fit  = v;
    tick();
    bus.ext_we   = 1'b0;
    mfit[a]      = v;
  endtask

  task automatic load_all(input logic signed [26:0] v);
    for (int i = 0; i < 16; i++) load(i, v);
  endtask

  task automatic ext_check(input string tag);
    sbq.push_back(ref_best());
    tick();
    pop_cmp(tag);
  endtask

  initial begin
    bus.seed     = 32'hA1EF_CDE5;
    bus.start    = 1'b0;
    bus.ext_we   = 1'b0;
    bus.ext_addr = '0;
    bus.ext_fit  = '0;
    #2;
    do_reset(32'hA1EF_CDE5);
    tick();
    chk_zero("idle_after_reset");

    // Directed generate/evaluate runs with the reference seed.
    run_start("start_a", 1'b0);
    tick();
    run_start("start_b", 1'b0);

    // Single winner at several slot positions.
    load_all(27'h7FF_FFFE);
    load(0, 27'h7FF_FFFF);
    ext_check("win0");
    for (int n = 0; n < 4; n++) begin
      int sl;
      sl = (n == 0) ? 3 : (n == 1) ? 5 : (n == 2) ? 6 : 8;
      load_all(27'h7FF_FFFE);
      load(sl, 27'h7FF_FFFF);
      ext_check("win_slot");
      chk("win_slot_idx", 32'(bus.best_index), 32'(sl));
    end

    // Nothing above the initial maximum, and ties.
    load_all(27'h400_0001);
    ext_check("all_init_max");
    load_all(27'h400_0000);
    ext_check("all_most_neg");
    load_all(27'h000_0010);
    load(2, 27'h000_0100);
    load(9, 27'h000_0100);
    ext_check("tie_2_9");
    chk("tie_idx", 32'(bus.best_index), 32'd2);

    // Start ignored while busy.
    run_start("double_start", 1'b1);

    // Reset in the middle of FILL.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    reset = 1'b0;
    #1;
    chk_zero("mid_fill_reset");
    tick();
    chk_zero("mid_fill_reset_hold");
    reset = 1'b1;
    clear_model();
    tick();
    chk_zero("after_abort");

    // Seed zero behaves as seed one.
    do_reset(32'h0);
    for (int r = 0; r < 6; r++) run_start("seed0", 1'b0);

    // Randomised mix of generate runs and bank loads.
    for (int r = 0; r < 120; r++) begin
      if (r % 20 == 0) do_reset($urandom);
      if (r % 2 == 0) begin
        run_start("rnd_start", 1'b0);
      end else begin
        logic signed [26:0] pool [3];
        pool[0] = 27'($urandom);
        pool[1] = 27'($urandom);
        pool[2] = 27'h400_0000;
        for (int i = 0; i < 16; i++) begin
          if ($urandom_range(0, 2) == 0) load(i, pool[$urandom_range(0, 2)]);
          else                          load(i, 27'($urandom));
        end
        ext_check("rnd_bank");
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
